// File: rtl/hazard_control_unit_if.sv
// Bundle between the MIPS pipeline (master) and the hazard controller (slave):
// ID/EX hazard inputs, memory busy, and the pipeline enable/flush/freeze controls.
interface hazard_control_unit_if;
  logic [4:0]  ra_pipe_id;
  logic [4:0]  rb_pipe_id;
  logic        ra_used_id;
  logic        rb_used_id;
  logic        MemToReg_pipe_ex;
  logic        RegWrite_pipe_ex;
  logic [4:0]  RegWriteDst_pipe_ex;
  logic        branch_taken_ex;
  logic        dmem_busy_mem;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_freeze;
  logic        mem_fault;
  logic [31:0] load_stall_count;
  logic [31:0] freeze_count;
  logic [31:0] flush_count;

  modport master (
    output ra_pipe_id, rb_pipe_id, ra_used_id, rb_used_id,
           MemToReg_pipe_ex, RegWrite_pipe_ex, RegWriteDst_pipe_ex,
           branch_taken_ex, dmem_busy_mem,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_freeze,
           mem_fault, load_stall_count, freeze_count, flush_count
  );

  modport slave (
    input  ra_pipe_id, rb_pipe_id, ra_used_id, rb_used_id,
           MemToReg_pipe_ex, RegWrite_pipe_ex, RegWriteDst_pipe_ex,
           branch_taken_ex, dmem_busy_mem,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_freeze,
           mem_fault, load_stall_count, freeze_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch flush, memory-busy freeze and watchdog for the 5-stage MIPS core.
// Define HAZARD_PERF_CNT_EN to build the stall/freeze/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input logic             clock,
  input logic             reset,
  hazard_control_unit_if.slave hz
);

  localparam int unsigned BCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [BCW-1:0] TIMEOUT_V = BCW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FAULT      = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       stall_cnt, stall_cnt_nxt;
  logic [BCW-1:0]   busy_cnt;
  logic             load_use;
  logic             timeout;
  logic             pc_we, ifid_we, flush, bubble, freeze, fault;

  assign load_use = hz.MemToReg_pipe_ex & hz.RegWrite_pipe_ex &
                    (hz.RegWriteDst_pipe_ex != 5'd0) &
                    ((hz.ra_used_id & (hz.ra_pipe_id == hz.RegWriteDst_pipe_ex)) |
                     (hz.rb_used_id & (hz.rb_pipe_id == hz.RegWriteDst_pipe_ex)));

  // Fault is reported in the very cycle the timeout is reached, not one later.
  assign timeout = (MEM_TIMEOUT != 0) && hz.dmem_busy_mem && (busy_cnt == TIMEOUT_V);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (!hz.dmem_busy_mem)
        busy_cnt <= '0;
      else if (busy_cnt != TIMEOUT_V)
        busy_cnt <= busy_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    flush         = 1'b0;
    bubble        = 1'b0;
    freeze        = 1'b0;
    fault         = 1'b0;
    if (reset) begin
      state_nxt = RUN;
    end else if (state == FAULT || timeout) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      freeze    = 1'b1;
      fault     = 1'b1;
      state_nxt = FAULT;
    end else if (hz.dmem_busy_mem) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      freeze  = 1'b1;
    end else if (state == LOAD_STALL) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (stall_cnt == 2'd1) begin
        state_nxt     = RUN;
        stall_cnt_nxt = '0;
      end else begin
        stall_cnt_nxt = stall_cnt - 2'd1;
      end
    end else if (hz.branch_taken_ex) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (load_use) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_nxt     = LOAD_STALL;
        stall_cnt_nxt = 2'(LOAD_LATENCY - 1);
      end
    end
  end

  assign hz.pc_write_en   = pc_we;
  assign hz.ifid_write_en = ifid_we;
  assign hz.ifid_flush    = flush;
  assign hz.idex_bubble   = bubble;
  assign hz.pipe_freeze   = freeze;
  assign hz.mem_fault     = fault;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, freeze_q, flush_q;
  logic        is_stall;

  // A bubble without a flush can only be a load-use stall cycle.
  assign is_stall = bubble & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      freeze_q <= '0;
      flush_q  <= '0;
    end else begin
      if (is_stall && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (freeze && freeze_q != '1)
        freeze_q <= freeze_q + 32'd1;
      if (flush && flush_q != '1)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.load_stall_count = stall_q;
  assign hz.freeze_count     = freeze_q;
  assign hz.flush_count      = flush_q;
`else
  assign hz.load_stall_count = '0;
  assign hz.freeze_count     = '0;
  assign hz.flush_count      = '0;
`endif

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID-stage forwarding logic. It detects load-use hazards that register forwarding cannot cover and inserts bubbles. It flushes wrong-path instructions on a taken branch/jump resolved in EX. It freezes the whole pipeline while data memory is busy, and runs a watchdog that latches a fault if memory never completes.

## Interface
- `LOAD_LATENCY`, 1 — bubbles inserted per load-use hazard (legal 1..3).
- `MEM_TIMEOUT`, 255 — consecutive `dmem_busy_mem` cycles that trigger a fault; 0 disables the watchdog.

Ports (clock and reset first):
- `clock`  in  1  — the single system clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `ra_pipe_id`, `rb_pipe_id`  in  5 each  — source registers of the instruction in ID.
- `ra_used_id`, `rb_used_id`  in  1 each  — the ID instruction actually reads ra / rb.
- `MemToReg_pipe_ex`, `RegWrite_pipe_ex`  in  1 each  — control bits of the instruction in EX.
- `RegWriteDst_pipe_ex`  in  5  — destination register of the instruction in EX.
- `branch_taken_ex`  in  1  — taken branch/jump resolved in EX (no delay slot).
- `dmem_busy_mem`  in  1  — data memory has not completed the MEM-stage access.
- `pc_write_en`  out  1  — PC may update.
- `ifid_write_en`  out  1  — IF/ID register may update.
- `ifid_flush`  out  1  — IF/ID loads a NOP.
- `idex_bubble`  out  1  — ID/EX loads a NOP (control bits zeroed).
- `pipe_freeze`  out  1  — hold ID/EX, EX/MEM and MEM/WB.
- `mem_fault`  out  1  — sticky watchdog fault.
- `load_stall_count`, `freeze_count`, `flush_count`  out  32 each  — performance counters (see Configuration).

## Operation
- The FSM has three states: RUN, LOAD_STALL and FAULT. There is also `stall_cnt` (2 bits) and `busy_cnt` (width clog2(MEM_TIMEOUT+1)).
- A load-use hazard is `MemToReg_pipe_ex & RegWrite_pipe_ex & (RegWriteDst_pipe_ex != 0)` combined with `(ra_used_id & ra_pipe_id == dst)` or `(rb_used_id & rb_pipe_id == dst)`.
- Outputs are combinational from the state and inputs. They use the following priority: reset > FAULT > busy > branch > load-use.
  - **Idle** (also while `reset`=1): pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
  - **FAULT**: pc_write_en=0, ifid_write_en=0, ifid_flush=0, idex_bubble=0, pipe_freeze=1, mem_fault=1.
  - **Busy** (`dmem_busy_mem`=1): same enables as FAULT, but mem_fault=0. The FSM state and `stall_cnt` hold.
  - **Branch** (RUN, `branch_taken_ex`=1, not busy): pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_bubble=1. A load-use hazard in the same cycle is ignored, because the ID instruction is squashed.
  - **Stall** (RUN with a load-use hazard, or any non-busy cycle in LOAD_STALL): pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0, pipe_freeze=0.
- Transitions:
  - RUN → LOAD_STALL happens on a Stall cycle when LOAD_LATENCY>1; `stall_cnt` is loaded with LOAD_LATENCY-1. With LOAD_LATENCY=1 the FSM stays in RUN.
  - In LOAD_STALL, each non-busy cycle decrements `stall_cnt`. When `stall_cnt`=1, the next state is RUN. Hazard detection and `branch_taken_ex` are ignored in LOAD_STALL, since EX holds a bubble.
  - Any state → FAULT when `busy_cnt` equals MEM_TIMEOUT and `dmem_busy_mem`=1 (MEM_TIMEOUT>0). FAULT exits only on reset.
- `busy_cnt` increments each cycle `dmem_busy_mem`=1, saturates at MEM_TIMEOUT, and clears when `dmem_busy_mem`=0.

## Timing
- Reset values: state=RUN, stall_cnt=0, busy_cnt=0, mem_fault=0, all perf counters 0.
- Zero-cycle decision latency: hazard and busy responses appear in the same cycle as the causing inputs.
- A load-use hazard produces exactly LOAD_LATENCY consecutive bubble cycles, not counting interleaved busy cycles.
- With the default MEM_TIMEOUT=255, busy held for cycles 1..255 asserts mem_fault from the 256th consecutive busy cycle. Busy dropping earlier clears busy_cnt.
- Asserting reset mid-stall or in FAULT returns the block to RUN on the next edge. The load being stalled is the pipeline's responsibility.

## Configuration
- `HAZARD_PERF_CNT_EN`, when defined, compiles in three saturating 32-bit counters:
  - `load_stall_count` increments per Stall cycle.
  - `freeze_count` increments per Busy or FAULT cycle.
  - `flush_count` increments per Branch cycle.
  - All three clear on reset.
- When the macro is undefined, the counter registers are absent and all three outputs are tied to 0.

## Test plan
- Load `lw $5` in EX with ID reading ra=5, ra_used=1, LOAD_LATENCY=1 → one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1; idle on the next cycle.
- The same hazard with LOAD_LATENCY=3, plus a busy pulse on the 2nd bubble → bubbles on 3 non-busy cycles, a freeze in between, then RUN.
- Destination $0, or rb match with rb_used=0 → no stall. An ALU writer (MemToReg=0) to a matching register → no stall.
- branch_taken_ex=1 together with a load-use hazard → ifid_flush=1, idex_bubble=1, pc_write_en=1, and no LOAD_STALL entry.
- MEM_TIMEOUT=4, busy held for 6 cycles → mem_fault=1 from the 5th busy cycle, held after busy drops until reset; pipe_freeze=1 throughout.
- With HAZARD_PERF_CNT_EN defined, 2 stalls, 1 flush and 3 busy cycles → counters read 2, 1, 3. With the macro undefined, all counters read 0.
